conv_out_ctrl: RTL

- Output-side counterpart of the convolution input controller.
- After a crossbar compute completes, it reads the column results out of the CIM tile array one column address per cycle.
- It sums partial sums across vertical tiles and assembles one value per output channel in a register bank.
- It then hands the bank to the downstream function/activation stage with a start/busy handshake.

---
 rtl/conv_out_ctrl_if.sv | 33 +++
 rtl/conv_out_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/conv_out_ctrl_if.sv
// Handshake and data bus between the output controller, the CIM tile
// array (read port) and the downstream function/activation stage.
interface conv_out_ctrl_if #(
    parameter int psum_size       = 16,
    parameter int output_channels = 5,
    parameter int xbar_size       = 256,
    parameter int v_cim_tiles     = 1
);
    localparam int h_cim_tiles = (output_channels + xbar_size - 1) / xbar_size;
    localparam int out_size    = psum_size + $clog2(v_cim_tiles);
    localparam int addr_w      = (xbar_size > 1) ? $clog2(xbar_size) : 1;

    logic                                                i_cim_done;
    logic                                                o_cim_re;
    logic [addr_w-1:0]                                   o_cim_addr;
    logic [h_cim_tiles*v_cim_tiles-1:0][psum_size-1:0]   i_cim_data;
    logic                                                i_func_busy;
    logic                                                o_start;
    logic                                                o_busy;
    logic [output_channels-1:0][out_size-1:0]            o_data;

    // controller side
    modport master (
        input  i_cim_done, i_cim_data, i_func_busy,
        output o_cim_re, o_cim_addr, o_start, o_busy, o_data
    );

    // tile array / downstream side
    modport slave (
        output i_cim_done, i_cim_data, i_func_busy,
        input  o_cim_re, o_cim_addr, o_start, o_busy, o_data
    );
endinterface

// File: rtl/conv_out_ctrl.sv
// Output controller for the CIM convolution path: streams column results
// out of the tile array, adds vertical-tile partial sums, assembles one
// value per output channel and hands the bank downstream.
module conv_out_ctrl #(
    parameter int psum_size       = 16,
    parameter int output_channels = 5,
    parameter int xbar_size       = 256,
    parameter int v_cim_tiles     = 1,
    parameter int h_cim_tiles     = (output_channels + xbar_size - 1) / xbar_size
) (
    input  logic              clk,
    input  logic              rst,
    conv_out_ctrl_if.master   bus
);
    localparam int out_size    = psum_size + $clog2(v_cim_tiles);
    localparam int addr_w      = (xbar_size > 1) ? $clog2(xbar_size) : 1;
    // a single horizontal tile only needs the used columns; with several
    // tiles every tile shares one address, so the full crossbar is walked
    localparam int count_limit = (h_cim_tiles > 1) ? xbar_size : output_channels;
    localparam logic [addr_w-1:0] last_addr = addr_w'(count_limit - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t                     state;
    logic [addr_w-1:0]          rd_addr;
    logic                       cap_valid;
    logic [addr_w-1:0]          cap_addr;
    logic signed [out_size-1:0] col_sum [h_cim_tiles];

    // sequencer: registered re/addr/busy/start so tile and downstream see clean levels
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_addr        <= '0;
            bus.o_cim_re   <= 1'b0;
            bus.o_cim_addr <= '0;
            bus.o_start    <= 1'b0;
            bus.o_busy     <= 1'b0;
        end else begin
            bus.o_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_cim_done) begin
                        state          <= READ;
                        bus.o_busy     <= 1'b1;
                        bus.o_cim_re   <= 1'b1;
                        bus.o_cim_addr <= rd_addr;
                    end
                end
                READ: begin
                    if (rd_addr == last_addr) begin
                        state          <= DRAIN;
                        rd_addr        <= '0;
                        bus.o_cim_re   <= 1'b0;
                        bus.o_cim_addr <= '0;
                    end else begin
                        rd_addr        <= rd_addr + 1'b1;
                        bus.o_cim_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: state <= HOLD;
                HOLD: begin
                    if (!bus.i_func_busy) begin
                        state       <= IDLE;
                        bus.o_start <= 1'b1;
                        bus.o_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sign-extend each vertical partial sum to out_size and add; the extra
    // clog2(v) bits guarantee the total cannot overflow
    always_comb begin
        for (int h = 0; h < h_cim_tiles; h++) begin
            col_sum[h] = '0;
            for (int v = 0; v < v_cim_tiles; v++)
                col_sum[h] = col_sum[h]
                           + out_size'(signed'(bus.i_cim_data[h*v_cim_tiles+v]));
        end
    end

    // capture: read data arrives one cycle after re/addr, so track them one cycle late;
    // columns past output_channels in the last tile match no channel and drop out
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid  <= 1'b0;
            cap_addr   <= '0;
            bus.o_data <= '0;
        end else begin
            cap_valid <= bus.o_cim_re;
            cap_addr  <= bus.o_cim_addr;
            if (cap_valid) begin
                for (int c = 0; c < output_channels; c++)
                    if (cap_addr == addr_w'(c % xbar_size))
                        bus.o_data[c] <= col_sum[c / xbar_size];
            end
        end
    end
endmodule
